// File: rtl/ram_march_bist_if.sv
`default_nettype none
// ============================================================================
//  Module      : ram_march_bist_if
//  Description : RAM port bundle between the March BIST controller (master)
//                and the single-port synchronous RAM (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface ram_march_bist_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;

    modport master (
        output mem_we,
        output mem_addr,
        output mem_din,
        input  mem_dout
    );

    modport slave (
        input  mem_we,
        input  mem_addr,
        input  mem_din,
        output mem_dout
    );
endinterface
`default_nettype wire

// File: rtl/ram_march_bist.sv
`default_nettype none
// ============================================================================
//  Module      : ram_march_bist
//  Description : March C- built-in self-test controller for a single-port
//                synchronous RAM with one cycle of read latency. Reports
//                pass/fail plus the first failing address and read data.
//                Optional macro RAM_BIST_ERRCNT_EN: adds a saturating 16-bit
//                mismatch counter and runs to completion instead of aborting
//                on the first mismatch.
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_march_bist #(
    parameter int               ADDR_W = 10,
    parameter int               DATA_W = 32,
    parameter logic [DATA_W-1:0] BG    = '0
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              start,
    output logic                   busy,
    output logic                   done,
    output logic                   fail,
    output logic [ADDR_W-1:0]      fail_addr,
    output logic [DATA_W-1:0]      fail_data,
`ifdef RAM_BIST_ERRCNT_EN
    output logic [15:0]            err_cnt,
`endif
    ram_march_bist_if.master       mem
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WR   = 3'd1,
        S_RD   = 3'd2,
        S_CW   = 3'd3,
        S_CMP  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    // March element indices
    localparam logic [2:0]        c_M0       = 3'd0;
    localparam logic [2:0]        c_M1       = 3'd1;
    localparam logic [2:0]        c_M2       = 3'd2;
    localparam logic [2:0]        c_M3       = 3'd3;
    localparam logic [2:0]        c_M4       = 3'd4;
    localparam logic [2:0]        c_M5       = 3'd5;
    localparam logic [ADDR_W-1:0] c_ADDR_MAX = '1;

    state_t              r_state, w_state_nxt;
    logic [2:0]          r_elem,  w_elem_nxt;
    logic [ADDR_W-1:0]   r_addr,  w_addr_nxt;
    logic                r_fail;
    logic [ADDR_W-1:0]   r_fail_addr;
    logic [DATA_W-1:0]   r_fail_data;

    logic [DATA_W-1:0]   w_exp;
    logic [DATA_W-1:0]   w_wval;
    logic                w_up;
    logic                w_elem_last;
    logic                w_mis;
    logic                w_abort;
    logic                w_accept;

    // Per-element expected read value, write value and address direction
    always_comb begin
        w_exp  = BG;
        w_wval = BG;
        w_up   = 1'b1;
        case (r_elem)
            c_M1:    begin w_exp = BG;  w_wval = ~BG; w_up = 1'b1; end
            c_M2:    begin w_exp = ~BG; w_wval = BG;  w_up = 1'b1; end
            c_M3:    begin w_exp = BG;  w_wval = ~BG; w_up = 1'b0; end
            c_M4:    begin w_exp = ~BG; w_wval = BG;  w_up = 1'b0; end
            c_M5:    begin w_exp = BG;  w_wval = BG;  w_up = 1'b0; end
            default: begin w_exp = BG;  w_wval = BG;  w_up = 1'b1; end
        endcase
    end

    assign w_elem_last = w_up ? (r_addr == c_ADDR_MAX) : (r_addr == '0);
    assign w_mis       = ((r_state == S_CW) || (r_state == S_CMP)) && (mem.mem_dout != w_exp);
    assign w_accept    = (r_state == S_IDLE) && start;

`ifdef RAM_BIST_ERRCNT_EN
    assign w_abort = 1'b0;
`else
    assign w_abort = w_mis;
`endif

    // Next-state, address sequencing and RAM port decode
    always_comb begin
        w_state_nxt  = r_state;
        w_elem_nxt   = r_elem;
        w_addr_nxt   = r_addr;
        mem.mem_we   = 1'b0;
        mem.mem_addr = '0;
        mem.mem_din  = '0;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_WR;
                    w_elem_nxt  = c_M0;
                    w_addr_nxt  = '0;
                end
            end
            S_WR: begin
                busy         = 1'b1;
                mem.mem_we   = 1'b1;
                mem.mem_addr = r_addr;
                mem.mem_din  = BG;
                if (r_addr == c_ADDR_MAX) begin
                    w_elem_nxt  = c_M1;
                    w_addr_nxt  = '0;
                    w_state_nxt = S_RD;
                end else begin
                    w_addr_nxt  = r_addr + 1'b1;
                end
            end
            S_RD: begin
                busy         = 1'b1;
                mem.mem_addr = r_addr;
                w_state_nxt  = (r_elem == c_M5) ? S_CMP : S_CW;
            end
            S_CW: begin
                busy         = 1'b1;
                mem.mem_addr = r_addr;
                mem.mem_din  = w_wval;
                if (w_abort) begin
                    // Leave the failing cell untouched so it can be inspected
                    w_state_nxt = S_DONE;
                end else begin
                    mem.mem_we  = 1'b1;
                    w_state_nxt = S_RD;
                    if (w_elem_last) begin
                        w_elem_nxt = r_elem + 3'd1;
                        // Only M2 runs upward after a reload; M3..M5 run downward
                        w_addr_nxt = (r_elem == c_M1) ? '0 : c_ADDR_MAX;
                    end else begin
                        w_addr_nxt = w_up ? (r_addr + 1'b1) : (r_addr - 1'b1);
                    end
                end
            end
            S_CMP: begin
                busy         = 1'b1;
                mem.mem_addr = r_addr;
                if (w_abort || (r_addr == '0)) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_addr_nxt  = r_addr - 1'b1;
                    w_state_nxt = S_RD;
                end
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Sequencer state, element and address registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_elem  <= c_M0;
            r_addr  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_elem  <= w_elem_nxt;
            r_addr  <= w_addr_nxt;
        end
    end

    // Sticky first-mismatch capture, cleared when a run is accepted
    always_ff @(posedge clk) begin
        if (rst || w_accept) begin
            r_fail      <= 1'b0;
            r_fail_addr <= '0;
            r_fail_data <= '0;
        end else if (w_mis && !r_fail) begin
            r_fail      <= 1'b1;
            r_fail_addr <= r_addr;
            r_fail_data <= mem.mem_dout;
        end
    end

    assign fail      = r_fail;
    assign fail_addr = r_fail_addr;
    assign fail_data = r_fail_data;

`ifdef RAM_BIST_ERRCNT_EN
    logic [15:0] r_err_cnt;

    // Saturating count of every mismatching compare in the run
    always_ff @(posedge clk) begin
        if (rst || w_accept) begin
            r_err_cnt <= '0;
        end else if (w_mis && (r_err_cnt != 16'hFFFF)) begin
            r_err_cnt <= r_err_cnt + 16'd1;
        end
    end

    assign err_cnt = r_err_cnt;
`endif

endmodule
`default_nettype wire
